cal_mem_arbiter: RTL
====================

# cal_mem_arbiter

Sequential arbiter that owns the shared memory bus between the CPU and the accelerator in the cal datapath. It accepts level requests from both masters, issues registered grants, and drives `arb_res` (coded `ARB_CPU`/`ARB_ACC` from `cal_head.v`), which the address/write mux encoder consumes to steer address and write data. It also produces the qualified memory write strobe and enforces a bounded accelerator tenure so the CPU is never locked out.

## Interface
Parameters:
- `ACC_MAX_CYC`, 16: maximum consecutive accelerator-owned cycles while `cpu_req` is pending; legal range 2..2^`CNT_W`-1.
- `STARVE_LIMIT`, 8: CPU-owned cycles with `acc_req` pending before forced handover (only with `CAL_ARB_STARVE_EN`).
- `CNT_W`, 5: width of the tenure and starvation counters.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cpu_req`  in  1  CPU bus request, level; held while the CPU wants the bus.
- `cpu_write`  in  1  CPU write qualifier, valid while `cpu_gnt`=1.
- `acc_req`  in  1  accelerator bus request, level.
- `acc_write_out`  in  1  accelerator write qualifier, valid while `acc_gnt`=1.
- `cpu_gnt`  out  1  CPU owns the bus this cycle (registered).
- `acc_gnt`  out  1  accelerator owns the bus this cycle (registered).
- `arb_res`  out  1  current or last owner, `ARB_CPU`/`ARB_ACC` (registered).
- `mem_we`  out  1  `(cpu_gnt & cpu_write) | (acc_gnt & acc_write_out)`, combinational from registered grants.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset state: IDLE; `cpu_gnt`=0, `acc_gnt`=0, `arb_res`=`ARB_CPU`, `busy`=0, counters 0, `mem_we`=0.
- States: IDLE, CPU_OWN, ACC_OWN, TURN (one-cycle dead cycle on every ownership change).
- IDLE: `cpu_req` -> CPU_OWN (CPU wins a tie); else `acc_req` -> ACC_OWN; else stay.
- CPU_OWN: `cpu_gnt`=1, `arb_res`=`ARB_CPU`. Leave when `cpu_req`=0: to TURN if `acc_req`=1, else IDLE.
- ACC_OWN: `acc_gnt`=1, `arb_res`=`ARB_ACC`. Tenure counter increments each cycle `cpu_req`=1, clears when `cpu_req`=0. Leave when `acc_req`=0 (to TURN if `cpu_req`, else IDLE) or when the counter reaches `ACC_MAX_CYC`-1 with `cpu_req`=1 (preempt -> TURN).
- TURN: both grants 0, `arb_res` holds the outgoing owner, `busy`=1; next state is the other master's OWN if it still requests, else IDLE.
- No grant ever asserts to both masters; `cpu_gnt & acc_gnt` is always 0.
- A master dropping its request loses its grant the following cycle; the write strobe follows the grant, so writes issued after request drop are not propagated.
- Counters saturate at 2^`CNT_W`-1; never wrap.

## Timing
- Request-to-grant latency from IDLE: 1 cycle (request sampled at edge N, grant high after edge N).
- Handover latency: owner drops request at edge N -> TURN after N -> other grant after N+1.
- Preemption: tenure reaches `ACC_MAX_CYC`-1 at edge N -> `acc_gnt` low after N+1, `cpu_gnt` high after N+2; accelerator sees exactly `ACC_MAX_CYC` granted cycles.
- `rst_n` low asserts immediately (asynchronous) mid-tenure: grants and `mem_we` drop without waiting for a clock; release is sampled on the next rising edge.

## Configuration
- `CAL_ARB_STARVE_EN` defined: starvation counter increments each CPU_OWN cycle with `acc_req`=1, clears otherwise; at `STARVE_LIMIT`-1 the CPU is preempted via TURN to ACC_OWN, CPU must re-request after ACC tenure.
- Not defined: CPU is never preempted; counter and `STARVE_LIMIT` logic absent; ACC waits for `cpu_req` to drop.

## Test plan
- Reset: hold `rst_n`=0 with both requests high -> all grants 0, `arb_res`=`ARB_CPU`; release -> `cpu_gnt`=1 one cycle later.
- Tie from IDLE: `cpu_req`=`acc_req`=1 same edge -> CPU_OWN; drop `cpu_req` -> one TURN cycle, then `acc_gnt`=1, `arb_res`=`ARB_ACC`.
- Preemption, `ACC_MAX_CYC`=4: ACC owns, `cpu_req` rises and stays -> `acc_gnt` high exactly 4 cycles, 1 TURN cycle, `cpu_gnt`=1.
- Write qualify: ACC owns with `acc_write_out`=1, `cpu_write`=1 -> `mem_we`=1 only via ACC; in TURN `mem_we`=0.
- Starvation (`CAL_ARB_STARVE_EN`, `STARVE_LIMIT`=8): CPU holds request, `acc_req`=1 -> `cpu_gnt` drops after 8 cycles, ACC granted after TURN; without macro CPU keeps grant indefinitely.
- Async reset mid-ACC_OWN: pulse `rst_n` low between edges -> `acc_gnt`, `mem_we` drop immediately, state IDLE, counters 0.

Source files
------------

// File: rtl/cal_mem_arbiter.sv
// cal_mem_arbiter: shared memory bus arbiter between CPU and accelerator with bounded accelerator tenure
// Ports: clk, rst_n (async active-low); cpu_req/cpu_write, acc_req/acc_write_out from the masters;
//        cpu_gnt/acc_gnt registered grants, arb_res registered owner code (ARB_CPU/ARB_ACC),
//        mem_we qualified write strobe, busy high outside IDLE.
// Optional: define CAL_ARB_STARVE_EN to let a waiting accelerator preempt the CPU after STARVE_LIMIT cycles.
module cal_mem_arbiter #(
   parameter int ACC_MAX_CYC  = 16,
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cpu_req,
   input  logic cpu_write,
   input  logic acc_req,
   input  logic acc_write_out,
   output logic cpu_gnt,
   output logic acc_gnt,
   output logic arb_res,
   output logic mem_we,
   output logic busy
);
   localparam logic ARB_CPU = 1'b0;
   localparam logic ARB_ACC = 1'b1;
   localparam logic [CNT_W-1:0] ACC_TOP    = CNT_W'(ACC_MAX_CYC - 1);
   localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_LIMIT - 1);
   typedef enum logic [1:0] {IDLE, CPU_OWN, ACC_OWN, TURN} state_t;
   state_t state_q, state_d;
   logic cpu_gnt_q, cpu_gnt_d, acc_gnt_q, acc_gnt_d, arb_res_q, arb_res_d;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic starve_hit;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction
`ifdef CAL_ARB_STARVE_EN
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   assign starve_hit = acc_req && (starve_cnt_q == STARVE_TOP);
   always_comb starve_cnt_d = (state_q == CPU_OWN && state_d == CPU_OWN && acc_req) ? sat_inc(starve_cnt_q) : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) starve_cnt_q <= '0;
      else        starve_cnt_q <= starve_cnt_d;
`else
   logic unused_starve;
   assign starve_hit    = 1'b0;
   assign unused_starve = ^STARVE_TOP;
`endif
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = cpu_req ? CPU_OWN : acc_req ? ACC_OWN : IDLE;
         CPU_OWN: state_d = (!cpu_req || starve_hit) ? (acc_req ? TURN : IDLE) : CPU_OWN;
         // preemption fires on the ACC_MAX_CYC-th cycle the CPU has been waiting
         ACC_OWN: state_d = (!acc_req || (cpu_req && acc_cnt_q == ACC_TOP)) ? (cpu_req ? TURN : IDLE) : ACC_OWN;
         // arb_res still names the outgoing owner here
         TURN:    state_d = (arb_res_q == ARB_CPU) ? (acc_req ? ACC_OWN : IDLE) : (cpu_req ? CPU_OWN : IDLE);
         default: state_d = IDLE;
      endcase
      cpu_gnt_d = state_d == CPU_OWN;
      acc_gnt_d = state_d == ACC_OWN;
      arb_res_d = cpu_gnt_d ? ARB_CPU : acc_gnt_d ? ARB_ACC : arb_res_q;
      acc_cnt_d = (state_q == ACC_OWN && state_d == ACC_OWN && cpu_req) ? sat_inc(acc_cnt_q) : '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         cpu_gnt_q <= 1'b0;
         acc_gnt_q <= 1'b0;
         arb_res_q <= ARB_CPU;
         acc_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cpu_gnt_q <= cpu_gnt_d;
         acc_gnt_q <= acc_gnt_d;
         arb_res_q <= arb_res_d;
         acc_cnt_q <= acc_cnt_d;
      end
   assign cpu_gnt = cpu_gnt_q;
   assign acc_gnt = acc_gnt_q;
   assign arb_res = arb_res_q;
   assign busy    = state_q != IDLE;
   assign mem_we  = (cpu_gnt_q & cpu_write) | (acc_gnt_q & acc_write_out);
   a_excl: assert property (@(posedge clk) disable iff (!rst_n) !(cpu_gnt_q && acc_gnt_q));
endmodule
